// File: rtl/laser_fire_ctrl.sv
// Laser burst sequencer: warm-up, burst limit, cooldown and energy/overheat lockout.
// All state advances on frame_tick; laser anchor tracks the player each tick.
module laser_fire_ctrl #(
    parameter int unsigned WARMUP_FRAMES   = 4,
    parameter int unsigned MAX_FIRE_FRAMES = 120,
    parameter int unsigned COOLDOWN_FRAMES = 30,
    parameter int unsigned ENERGY_MAX      = 255,
    parameter int unsigned DRAIN           = 2,
    parameter int unsigned RECHARGE        = 1,
    parameter int unsigned FIRE_MIN        = 32,
    parameter int unsigned X_OFFSET        = 7,
    parameter int unsigned Y_OFFSET        = 1,
    parameter int unsigned MAX_X           = 384,
    parameter int unsigned RESET_X         = 192,
    parameter int unsigned RESET_Y         = 399
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       fire_btn,
    input  logic       player_alive,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    output logic       laser_active,
    output logic [9:0] laser_x,
    output logic [9:0] laser_y,
    output logic [7:0] energy,
    output logic       overheat,
    output logic       fire_start
);

    typedef enum logic [2:0] {
        StIdle,
        StWarmup,
        StFiring,
        StCooldown,
        StOverheat
    } state_e;

    localparam logic signed [10:0] XLimit = 11'(MAX_X - 16);

    state_e      state;
    logic [15:0] cnt;

    logic [8:0]         energy_add;
    logic [8:0]         energy_sub;
    logic [7:0]         energy_rech;
    logic [7:0]         energy_drain;
    logic               energy_full;
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic [9:0]         x_next;
    logic [9:0]         y_next;

    // 9-bit energy arithmetic, saturated at both ends
    assign energy_add   = {1'b0, energy} + 9'(RECHARGE);
    assign energy_sub   = {1'b0, energy} - 9'(DRAIN);
    assign energy_rech  = (energy_add > 9'(ENERGY_MAX)) ? 8'(ENERGY_MAX) : energy_add[7:0];
    assign energy_drain = energy_sub[8] ? 8'd0 : energy_sub[7:0];
    assign energy_full  = (energy == 8'(ENERGY_MAX));

    assign dx = signed'({1'b0, player_x}) - signed'(11'(X_OFFSET));
    assign dy = signed'({1'b0, player_y}) - signed'(11'(Y_OFFSET));

    always_comb begin
        x_next = dx[9:0];
        if (dx < 0) begin
            x_next = '0;
        end else if (dx > XLimit) begin
            x_next = XLimit[9:0];
        end
        y_next = (dy < 0) ? 10'd0 : dy[9:0];
    end

    assign laser_active = (state == StFiring);
    assign overheat     = (state == StOverheat);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= StIdle;
            cnt        <= '0;
            energy     <= 8'(ENERGY_MAX);
            laser_x    <= 10'(RESET_X);
            laser_y    <= 10'(RESET_Y);
            fire_start <= 1'b0;
        end else begin
            fire_start <= 1'b0;
            if (frame_tick) begin
                laser_x <= x_next;
                laser_y <= y_next;
                unique case (state)
                    StIdle: begin
                        energy <= energy_rech;
                        if (fire_btn && player_alive && energy >= 8'(FIRE_MIN)) begin
                            state <= StWarmup;
                            cnt   <= '0;
                        end
                    end
                    StWarmup: begin
                        if (!fire_btn || !player_alive) begin
                            state <= StIdle;
                            cnt   <= '0;
                        end else if (cnt == 16'(WARMUP_FRAMES - 1)) begin
                            state      <= StFiring;
                            cnt        <= '0;
                            fire_start <= 1'b1;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    StFiring: begin
                        if (!player_alive || !fire_btn) begin
                            state <= StCooldown;
                            cnt   <= '0;
                        end else if (energy <= 8'(DRAIN)) begin
                            energy <= '0;
                            state  <= StOverheat;
                            cnt    <= '0;
                        end else begin
                            energy <= energy_drain;
                            if (cnt == 16'(MAX_FIRE_FRAMES - 1)) begin
                                state <= StCooldown;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 16'd1;
                            end
                        end
                    end
                    StCooldown: begin
                        if (cnt == 16'(COOLDOWN_FRAMES - 1)) begin
                            state <= StIdle;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    StOverheat: begin
                        energy <= energy_rech;
                        // exit only once energy was already full and the trigger is let go
                        if (energy_full && !fire_btn) begin
                            state <= StIdle;
                            cnt   <= '0;
                        end
                    end
                    default: begin
                        state <= StIdle;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_laser_fire_ctrl.sv
// Directed bench for laser_fire_ctrl: default instance plus a long-burst instance
// (MAX_FIRE_FRAMES=200) used to reach the overheat lockout.
module tb_laser_fire_ctrl;

    logic       clk;
    logic       clk_en;
    logic       reset;
    logic       frame_tick;
    logic       fire_a, alive_a;
    logic       fire_b, alive_b;
    logic [9:0] player_x, player_y;

    logic       act_a, oh_a, fs_a;
    logic [9:0] lx_a, ly_a;
    logic [7:0] en_a;
    logic       act_b, oh_b, fs_b;
    logic [9:0] lx_b, ly_b;
    logic [7:0] en_b;

    int checks = 0;
    int errors = 0;

    laser_fire_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .fire_btn     (fire_a),
        .player_alive (alive_a),
        .player_x     (player_x),
        .player_y     (player_y),
        .laser_active (act_a),
        .laser_x      (lx_a),
        .laser_y      (ly_a),
        .energy       (en_a),
        .overheat     (oh_a),
        .fire_start   (fs_a)
    );

    laser_fire_ctrl #(.MAX_FIRE_FRAMES(200)) dut_long (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .fire_btn     (fire_b),
        .player_alive (alive_b),
        .player_x     (player_x),
        .player_y     (player_y),
        .laser_active (act_b),
        .laser_x      (lx_b),
        .laser_y      (ly_b),
        .energy       (en_b),
        .overheat     (oh_b),
        .fire_start   (fs_b)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        clk_en     = 1'b0;
        reset      = 1'b1;
        frame_tick = 1'b0;
        fire_a     = 1'b0;
        alive_a    = 1'b1;
        fire_b     = 1'b0;
        alive_b    = 1'b1;
        player_x   = 10'd200;
        player_y   = 10'd300;
        #1 reset = 1'b0;
        #2;
        // reset values with no clock edges at all
        check("rst_x", lx_a, 192);
        check("rst_y", ly_a, 399);
        check("rst_energy", en_a, 255);
        check("rst_active", act_a, 0);
        check("rst_overheat", oh_a, 0);
        check("rst_fire_start", fs_a, 0);

        clk_en = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("no_tick_x", lx_a, 192);
        check("no_tick_y", ly_a, 399);
        tick();
        check("pos_x", lx_a, 193);
        check("pos_y", ly_a, 299);
        ticks(2);
        check("idle_energy", en_a, 255);

        // full burst on the default instance
        fire_a = 1'b1;
        tick();
        check("warm1_active", act_a, 0);
        check("warm1_fs", fs_a, 0);
        ticks(3);
        check("warm4_fs", fs_a, 0);
        tick();
        check("fire_fs", fs_a, 1);
        check("fire_active", act_a, 1);
        check("fire_energy", en_a, 255);
        @(negedge clk);
        check("fs_one_clk", fs_a, 0);
        ticks(119);
        check("burst119_active", act_a, 1);
        check("burst119_energy", en_a, 17);
        tick();
        check("burst_end_active", act_a, 0);
        check("burst_end_energy", en_a, 15);
        ticks(30);
        check("cool_energy", en_a, 15);
        ticks(17);
        check("recharge17_energy", en_a, 32);
        tick();
        check("rewarm_energy", en_a, 33);
        tick();
        check("warm_hold_energy", en_a, 33);
        ticks(3);
        check("refire_fs", fs_a, 1);
        check("refire_active", act_a, 1);
        tick();
        check("drain_energy", en_a, 31);
        alive_a = 1'b0;
        tick();
        check("dead_active", act_a, 0);
        check("dead_no_drain", en_a, 31);
        alive_a = 1'b1;
        fire_a  = 1'b0;

        // overheat on the long-burst instance
        fire_b = 1'b1;
        ticks(5);
        check("oh_fire_fs", fs_b, 1);
        ticks(127);
        check("oh_drain127_energy", en_b, 1);
        check("oh_drain127_active", act_b, 1);
        tick();
        check("oh_energy", en_b, 0);
        check("oh_flag", oh_b, 1);
        check("oh_active", act_b, 0);
        fire_b = 1'b0;
        ticks(255);
        check("oh_full_energy", en_b, 255);
        check("oh_full_flag", oh_b, 1);
        fire_b = 1'b1;
        tick();
        check("oh_held_flag", oh_b, 1);
        fire_b = 1'b0;
        tick();
        check("oh_exit_flag", oh_b, 0);
        check("oh_exit_energy", en_b, 255);

        // async reset mid-burst
        fire_b = 1'b1;
        ticks(5);
        check("ar_fs", fs_b, 1);
        tick();
        check("ar_active_pre", act_b, 1);
        check("ar_energy_pre", en_b, 253);
        #2 reset = 1'b0;
        #1;
        check("ar_active", act_b, 0);
        check("ar_energy", en_b, 255);
        check("ar_x", lx_b, 192);
        fire_b = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // warm-up abort on the default instance
        fire_a = 1'b1;
        tick();
        fire_a = 1'b0;
        tick();
        check("abort_fs", fs_a, 0);
        check("abort_energy", en_a, 255);
        ticks(4);
        check("abort_active", act_a, 0);

        // position clamping
        player_x = 10'd3;
        tick();
        check("clamp_x_low", lx_a, 0);
        player_x = 10'd380;
        tick();
        check("clamp_x_high", lx_a, 368);
        player_x = 10'd374;
        player_y = 10'd0;
        tick();
        check("x_below_limit", lx_a, 367);
        check("clamp_y_low", ly_a, 0);
        player_x = 10'd7;
        player_y = 10'd1;
        tick();
        check("x_offset_edge", lx_a, 0);
        check("y_offset_edge", ly_a, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/laser_fire_ctrl.md
Name: laser_fire_ctrl

Overview:
- Sequences the player laser sprite block: decides when the laser is drawn and where it is anchored.
- Models a warm-up delay, a maximum burst length, a post-burst cooldown and an energy budget with an overheat lockout.
- Sits between player/input logic and the laser renderer. It drives the renderer's shooting gate and its anchor position.
- All state advances only on the one-cycle frame_tick, issued once per video frame.

Parameters:
- WARMUP_FRAMES, 4: frame ticks fire_btn must be held before the beam appears.
- MAX_FIRE_FRAMES, 120: maximum frame ticks in one burst.
- COOLDOWN_FRAMES, 30: frame ticks after a burst before re-arming.
- ENERGY_MAX, 255: full energy value; energy is 8 bits.
- DRAIN, 2: energy removed per FIRING tick.
- RECHARGE, 1: energy added per IDLE/OVERHEAT tick.
- FIRE_MIN, 32: minimum energy required to start warm-up.
- X_OFFSET, 7: laser_x = player_x - X_OFFSET.
- Y_OFFSET, 1: laser_y = player_y - Y_OFFSET.
- MAX_X, 384: playfield width; laser_x is clamped to MAX_X-16.
- RESET_X, 192: laser_x reset value.
- RESET_Y, 399: laser_y reset value.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset; asserted when 0.
- frame_tick, input, 1: one-clk pulse per frame; all updates qualify on it.
- fire_btn, input, 1: fire request, already synchronous and debounced.
- player_alive, input, 1: 0 forces the beam off and blocks firing.
- player_x, input, 10: player sprite x.
- player_y, input, 10: player sprite y.
- laser_active, output, 1: shooting gate to the laser renderer.
- laser_x, output, 10: laser anchor x.
- laser_y, output, 10: laser anchor y.
- energy, output, 8: current energy, for the HUD bar.
- overheat, output, 1: high while in OVERHEAT.
- fire_start, output, 1: one-clk pulse when a burst begins, for sound.

Behaviour:
- Reset values (applied immediately, no clock needed): state=IDLE, cnt=0, energy=ENERGY_MAX, laser_x=RESET_X, laser_y=RESET_Y, laser_active=0, overheat=0, fire_start=0.
- All outputs are registered. Any change appears on the clk edge that samples frame_tick=1.
- Without frame_tick, nothing changes except fire_start, which clears after one cycle.
- Position update, on every tick in every state:
  - laser_x = 0 if player_x < X_OFFSET; MAX_X-16 if player_x - X_OFFSET > MAX_X-16; otherwise player_x - X_OFFSET.
  - laser_y = 0 if player_y < Y_OFFSET; otherwise player_y - Y_OFFSET.
- IDLE (laser_active=0), on tick:
  - energy = min(energy + RECHARGE, ENERGY_MAX).
  - If fire_btn && player_alive && energy >= FIRE_MIN (pre-update value): go to WARMUP, cnt=0.
- WARMUP (laser_active=0), on tick:
  - If !fire_btn || !player_alive: go to IDLE. No energy change.
  - Else if cnt == WARMUP_FRAMES-1: go to FIRING, cnt=0, fire_start=1 for exactly one clk.
  - Else cnt++.
- FIRING (laser_active=1), on tick, checked in priority order:
  - !player_alive || !fire_btn: go to COOLDOWN, cnt=0, no drain.
  - energy <= DRAIN: energy=0, go to OVERHEAT.
  - Otherwise energy -= DRAIN. Then if cnt == MAX_FIRE_FRAMES-1, go to COOLDOWN with cnt=0; else cnt++.
- COOLDOWN (laser_active=0): no recharge. On tick, if cnt == COOLDOWN_FRAMES-1, go to IDLE with cnt=0; else cnt++.
- OVERHEAT (laser_active=0, overheat=1), on tick:
  - energy = min(energy + RECHARGE, ENERGY_MAX).
  - Exit to IDLE only when the pre-update energy == ENERGY_MAX and fire_btn=0.
  - If fire_btn is held while energy is full, remain in OVERHEAT.
- laser_active and overheat are decoded from the registered state.
- Reset asserted mid-state aborts the operation at once. After reset releases, the first tick behaves as IDLE.
- Arithmetic:
  - energy add/subtract is computed 9 bits wide, then saturated.
  - Position subtraction is computed 11 bits wide, signed, before clamping.

Test Plan:
- Reset check: hold reset=0 with no clk edges → laser_x=192, laser_y=399, energy=255, laser_active=0, overheat=0. Release and issue 3 ticks with fire_btn=0 → energy stays 255.
- Full burst: hold fire_btn=1 from IDLE.
  - Tick 1 enters WARMUP; fire_start pulses at tick 5; laser_active=1.
  - After 120 FIRING ticks the block is in COOLDOWN with energy=15.
  - After 30 more ticks it is IDLE.
  - With fire_btn still held it re-warms only after 17 recharge ticks (energy=32).
- Overheat (MAX_FIRE_FRAMES=200): fire held.
  - After 127 drains energy=1. Tick 128 → energy=0, overheat=1, laser_active=0.
  - Release fire; after 255 recharge ticks energy=255. The next tick gives IDLE, overheat=0.
- Aborts:
  - fire_btn released at the 2nd WARMUP tick → IDLE, no fire_start, energy=255.
  - player_alive=0 during FIRING → COOLDOWN on that tick, no drain.
- Position: player (200,300) → laser (193,299), but only after a tick. player_x=3 → laser_x=0. player_x=380 → laser_x=368. player_y=0 → laser_y=0.
- Async reset mid-FIRING: drive reset=0 between clk edges → laser_active=0 and energy=255 immediately, with no clock edge required.
